// File: rtl/axi_read_arbiter_if.sv
// ============================================================================
// Module      : axi_read_arbiter_if
// Description : IC/DC read-request ports and the shared AXI AR/R channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_read_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  ic_arvalid;
    logic [ADDR_WIDTH-1:0] ic_araddr;
    logic [7:0]            ic_arlen;
    logic [2:0]            ic_arsize;
    logic [1:0]            ic_arburst;
    logic                  ic_rready;
    logic                  ic_arready;
    logic                  ic_rvalid;
    logic                  ic_rlast;
    logic [DATA_WIDTH-1:0] ic_rdata;

    logic                  dc_arvalid;
    logic [ADDR_WIDTH-1:0] dc_araddr;
    logic [7:0]            dc_arlen;
    logic [2:0]            dc_arsize;
    logic [1:0]            dc_arburst;
    logic                  dc_rready;
    logic                  dc_arready;
    logic                  dc_rvalid;
    logic                  dc_rlast;
    logic [DATA_WIDTH-1:0] dc_rdata;

    logic                  m_axi_arvalid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arready;
    logic                  m_axi_rvalid;
    logic                  m_axi_rlast;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic                  m_axi_rready;

    // Arbiter side
    modport slave (
        input  ic_arvalid, ic_araddr, ic_arlen, ic_arsize, ic_arburst, ic_rready,
        output ic_arready, ic_rvalid, ic_rlast, ic_rdata,
        input  dc_arvalid, dc_araddr, dc_arlen, dc_arsize, dc_arburst, dc_rready,
        output dc_arready, dc_rvalid, dc_rlast, dc_rdata,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rdata,
        output m_axi_rready
    );

    // Caches plus memory side
    modport master (
        output ic_arvalid, ic_araddr, ic_arlen, ic_arsize, ic_arburst, ic_rready,
        input  ic_arready, ic_rvalid, ic_rlast, ic_rdata,
        output dc_arvalid, dc_araddr, dc_arlen, dc_arsize, dc_arburst, dc_rready,
        input  dc_arready, dc_rvalid, dc_rlast, dc_rdata,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rdata,
        input  m_axi_rready
    );
endinterface

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// ============================================================================
// Module      : axi_read_arbiter
// Description : Shares one AXI read channel between IC and DC; one burst at a
//               time. Optional macro ARB_ROUND_ROBIN_EN selects round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    axi_read_arbiter_if.slave  bus,
    output logic               instruction_cache_reading,
    output logic               data_cache_reading,
    output logic               burst_error
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic c_GRANT_IC = 1'b0;
    localparam logic c_GRANT_DC = 1'b1;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_grant;
    logic                  w_grant_next;
    logic                  r_last_grant;
    logic                  w_last_grant_next;
    logic [7:0]            r_beat_cnt;
    logic [7:0]            w_beat_cnt_next;
    logic                  r_burst_error;
    logic                  w_burst_error_next;
    logic                  r_ic_reading;
    logic                  r_dc_reading;
    logic                  w_pick;
    logic                  w_beat;
    logic [ADDR_WIDTH-1:0] w_araddr;
    logic [DATA_WIDTH-1:0] w_zero_data;

    assign w_zero_data = {DATA_WIDTH{1'b0}};
    assign w_araddr    = (r_grant == c_GRANT_DC) ? bus.dc_araddr : bus.ic_araddr;
    assign w_beat      = bus.m_axi_rvalid & bus.m_axi_rready;

    // Tie-break only matters when both caches request in the same cycle
    always_comb begin
        w_pick = bus.dc_arvalid ? c_GRANT_DC : c_GRANT_IC;
        if (bus.ic_arvalid && bus.dc_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_pick = ~r_last_grant;
`else
            w_pick = c_GRANT_DC;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= c_GRANT_IC;
            r_last_grant  <= c_GRANT_IC;
            r_beat_cnt    <= 8'd0;
            r_burst_error <= 1'b0;
            r_ic_reading  <= 1'b0;
            r_dc_reading  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_last_grant  <= w_last_grant_next;
            r_beat_cnt    <= w_beat_cnt_next;
            r_burst_error <= w_burst_error_next;
            r_ic_reading  <= (w_state_next != S_IDLE) && (w_grant_next == c_GRANT_IC);
            r_dc_reading  <= (w_state_next != S_IDLE) && (w_grant_next == c_GRANT_DC);
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        w_last_grant_next  = r_last_grant;
        w_beat_cnt_next    = r_beat_cnt;
        w_burst_error_next = r_burst_error;

        bus.m_axi_arvalid  = 1'b0;
        bus.m_axi_araddr   = {ADDR_WIDTH{1'b0}};
        bus.m_axi_arlen    = 8'd0;
        bus.m_axi_arsize   = 3'd0;
        bus.m_axi_arburst  = 2'd0;
        bus.m_axi_rready   = 1'b0;
        bus.ic_arready     = 1'b0;
        bus.ic_rvalid      = 1'b0;
        bus.ic_rlast       = 1'b0;
        bus.ic_rdata       = w_zero_data;
        bus.dc_arready     = 1'b0;
        bus.dc_rvalid      = 1'b0;
        bus.dc_rlast       = 1'b0;
        bus.dc_rdata       = w_zero_data;

        case (r_state)
            S_IDLE: begin
                if (bus.ic_arvalid || bus.dc_arvalid) begin
                    w_state_next      = S_ADDR;
                    w_grant_next      = w_pick;
                    w_last_grant_next = w_pick;
                end
            end
            S_ADDR: begin
                bus.m_axi_araddr = w_araddr;
                if (r_grant == c_GRANT_DC) begin
                    bus.m_axi_arvalid = bus.dc_arvalid;
                    bus.m_axi_arlen   = bus.dc_arlen;
                    bus.m_axi_arsize  = bus.dc_arsize;
                    bus.m_axi_arburst = bus.dc_arburst;
                    bus.dc_arready    = bus.m_axi_arready;
                end else begin
                    bus.m_axi_arvalid = bus.ic_arvalid;
                    bus.m_axi_arlen   = bus.ic_arlen;
                    bus.m_axi_arsize  = bus.ic_arsize;
                    bus.m_axi_arburst = bus.ic_arburst;
                    bus.ic_arready    = bus.m_axi_arready;
                end
                if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                    w_beat_cnt_next = bus.m_axi_arlen;
                    w_state_next    = S_DATA;
                end
            end
            S_DATA: begin
                if (r_grant == c_GRANT_DC) begin
                    bus.m_axi_rready = bus.dc_rready;
                    bus.dc_rvalid    = bus.m_axi_rvalid;
                    bus.dc_rlast     = bus.m_axi_rlast;
                    bus.dc_rdata     = bus.m_axi_rdata;
                end else begin
                    bus.m_axi_rready = bus.ic_rready;
                    bus.ic_rvalid    = bus.m_axi_rvalid;
                    bus.ic_rlast     = bus.m_axi_rlast;
                    bus.ic_rdata     = bus.m_axi_rdata;
                end
                if (w_beat) begin
                    if (r_beat_cnt != 8'd0) begin
                        w_beat_cnt_next = r_beat_cnt - 8'd1;
                    end
                    // Early or missing rlast is flagged, but only rlast ends the burst
                    if (bus.m_axi_rlast != (r_beat_cnt == 8'd0)) begin
                        w_burst_error_next = 1'b1;
                    end
                    if (bus.m_axi_rlast) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign instruction_cache_reading = r_ic_reading;
    assign data_cache_reading        = r_dc_reading;
    assign burst_error               = r_burst_error;

endmodule

`default_nettype wire
